// File: rtl/serial_sum_collector.sv
// Serial sum collector: shifts adder sum bits LSB-first into a word, hands it off via valid/ready.
// Optional sticky overflow flag enabled by defining SERIAL_SUM_OVF_STICKY_EN.
module serial_sum_collector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sum_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_carry,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             ovf_sticky
);

    typedef enum logic {COLLECT, FULL} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            shreg_q <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (flush) begin
            state_q <= COLLECT;
            shreg_q <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        shreg_q <= {sum_in, shreg_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + ONE;
                        carry_q <= cout_in;
                        if (cnt_q == LAST) begin
                            state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    // carry stays as captured; only count and data restart
                    if (out_ready) begin
                        state_q <= COLLECT;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef SERIAL_SUM_OVF_STICKY_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
        end else if (state_q == FULL && out_ready && carry_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_sticky = ovf_q;
`else
    assign ovf_sticky = 1'b0;
`endif

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == FULL);
    assign out_word  = shreg_q;
    assign out_carry = carry_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed table-driven bench for serial_sum_collector (WIDTH=4).
// Checks ovf_sticky against the build selected by SERIAL_SUM_OVF_STICKY_EN.
module tb_serial_sum_collector;

    localparam int W  = 4;
    localparam int CW = 5;

`ifdef SERIAL_SUM_OVF_STICKY_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          sum_in;
    logic          cout_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_carry;
    logic [CW-1:0] bit_cnt;
    logic          ovf_sticky;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_sum_collector #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .cout_in(cout_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_carry(out_carry),
        .bit_cnt(bit_cnt), .ovf_sticky(ovf_sticky)
    );

    typedef struct {
        logic         iv, s, c, rdy, fl;
        logic         e_vld, e_rdy;
        logic [W-1:0] e_word;
        logic         e_carry;
        int           e_cnt;
        logic         e_ovf;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("out_valid", idx, 32'(out_valid), 32'(v.e_vld));
        chk("in_ready", idx, 32'(in_ready), 32'(v.e_rdy));
        chk("out_word", idx, 32'(out_word), 32'(v.e_word));
        chk("out_carry", idx, 32'(out_carry), 32'(v.e_carry));
        chk("bit_cnt", idx, 32'(bit_cnt), 32'(v.e_cnt));
        chk("ovf", idx, 32'(ovf_sticky), 32'(v.e_ovf & OVF_EN));
    endtask

    task automatic add(input logic iv, s, c, rdy, fl,
                       input logic vld, rd, input logic [W-1:0] wd,
                       input logic cy, input int cn, input logic ov);
        vec_t v;
        v.iv = iv; v.s = s; v.c = c; v.rdy = rdy; v.fl = fl;
        v.e_vld = vld; v.e_rdy = rd; v.e_word = wd;
        v.e_carry = cy; v.e_cnt = cn; v.e_ovf = ov;
        vt.push_back(v);
    endtask

    task automatic drive(input logic iv, s, c, rdy, fl);
        @(negedge clk);
        in_valid = iv; sum_in = s; cout_in = c;
        out_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sum_in = 1'b0; cout_in = 1'b0; out_ready = 1'b0;

        //  iv s c rdy fl | vld rdy word     carry cnt ovf
        add(1, 1, 0, 1, 0,  0, 1, 4'b1000, 0, 1, 0);
        add(1, 0, 0, 1, 0,  0, 1, 4'b0100, 0, 2, 0);
        add(1, 1, 0, 1, 0,  0, 1, 4'b1010, 0, 3, 0);
        add(1, 1, 1, 1, 0,  1, 0, 4'b1101, 1, 4, 0);
        add(1, 0, 0, 1, 0,  0, 1, 4'b0000, 1, 0, 1);
        add(1, 0, 0, 1, 0,  0, 1, 4'b0000, 0, 1, 1);
        add(1, 1, 0, 1, 0,  0, 1, 4'b1000, 0, 2, 1);
        add(1, 1, 0, 0, 0,  0, 1, 4'b1100, 0, 3, 1);
        add(1, 0, 0, 0, 0,  1, 0, 4'b0110, 0, 4, 1);
        for (int i = 0; i < 5; i++)
            add(1, 1, 1, 0, 0,  1, 0, 4'b0110, 0, 4, 1);
        add(1, 1, 1, 1, 0,  0, 1, 4'b0000, 0, 0, 1);
        add(1, 0, 0, 0, 0,  0, 1, 4'b0000, 0, 1, 1);
        add(0, 1, 1, 0, 0,  0, 1, 4'b0000, 0, 1, 1);
        add(0, 1, 1, 0, 0,  0, 1, 4'b0000, 0, 1, 1);
        add(1, 1, 0, 0, 0,  0, 1, 4'b1000, 0, 2, 1);
        add(0, 0, 1, 0, 0,  0, 1, 4'b1000, 0, 2, 1);
        add(1, 1, 0, 0, 0,  0, 1, 4'b1100, 0, 3, 1);
        add(1, 0, 1, 0, 0,  1, 0, 4'b0110, 1, 4, 1);
        add(1, 1, 1, 1, 1,  0, 1, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 1, 0,  0, 1, 4'b1000, 1, 1, 0);
        add(1, 1, 0, 1, 0,  0, 1, 4'b1100, 0, 2, 0);
        add(1, 1, 1, 1, 1,  0, 1, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 0,  0, 1, 4'b1000, 0, 1, 0);
        add(1, 0, 0, 0, 0,  0, 1, 4'b0100, 0, 2, 0);
        add(1, 0, 0, 0, 0,  0, 1, 4'b0010, 0, 3, 0);
        add(1, 1, 0, 0, 0,  1, 0, 4'b1001, 0, 4, 0);
        add(0, 0, 0, 1, 0,  0, 1, 4'b0000, 0, 0, 0);

        #23;
        chk("rst_cnt", 0, 32'(bit_cnt), 0);
        chk("rst_vld", 0, 32'(out_valid), 0);
        chk("rst_word", 0, 32'(out_word), 0);
        chk("rst_ovf", 0, 32'(ovf_sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 0, 32'(in_ready), 1);

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            drive(v.iv, v.s, v.c, v.rdy, v.fl);
            chk_all(i, v);
        end

        drive(1, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; sum_in = 1'b1; cout_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_cnt", 0, 32'(bit_cnt), 0);
        chk("amid_word", 0, 32'(out_word), 0);
        chk("amid_vld", 0, 32'(out_valid), 0);
        chk("amid_cy", 0, 32'(out_carry), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arel_rdy", 0, 32'(in_ready), 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk("fresh_cnt3", 0, 32'(bit_cnt), 3);
        drive(1, 1, 1, 0, 0);
        chk("fresh_word", 0, 32'(out_word), 32'hf);
        chk("fresh_cy", 0, 32'(out_carry), 1);
        chk("fresh_vld", 0, 32'(out_valid), 1);
        chk("fresh_cnt", 0, 32'(bit_cnt), 4);
        drive(0, 0, 0, 1, 0);
        chk("fresh_drain", 0, 32'(out_valid), 0);
        chk("fresh_ovf", 0, 32'(ovf_sticky), 32'(OVF_EN));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
- Downstream consumer of the bit-level adder stage (the circuit3 sum/carry cell).
- Each accepted cycle, takes one sum bit and that bit's carry-out, and shifts the sum bits LSB-first into a WIDTH-bit word.
- After WIDTH bits, presents the assembled word plus the final carry on a valid/ready output port.
- Holds the word until the next stage (register file / display stage) accepts it.

Parameters:
- WIDTH, 4, number of sum bits per assembled word; legal range 2..32.
- CNT_W, 5, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of the frame in progress, active-high.
- in_valid  input  1  sum_in/cout_in carry a valid bit this cycle.
- in_ready  output  1  block can accept a bit this cycle.
- sum_in  input  1  sum bit from the adder stage.
- cout_in  input  1  carry-out from the adder stage for the same bit.
- out_valid  output  1  out_word/out_carry hold a complete word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_word  output  WIDTH  assembled word; bit 0 is the first accepted sum bit.
- out_carry  output  1  cout_in captured with the last (MSB) bit.
- bit_cnt  output  CNT_W  number of bits accepted in the current frame.
- ovf_sticky  output  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), named as the codebase names clock and reset.
- rst_n low (asynchronous) clears everything:
  - state = COLLECT, shift register = 0, bit_cnt = 0, out_carry = 0, out_valid = 0, ovf_sticky = 0.
  - in_ready reads 1 once rst_n deasserts.
- Reset asserted mid-frame or while FULL discards all data; no partial word is ever presented.
- FSM has two states, COLLECT and FULL. in_ready = (state==COLLECT); out_valid = (state==FULL). Both are decoded from registered state, with no combinational path from any input.
- COLLECT, accept = in_valid && in_ready:
  - shift register <= {sum_in, shreg[WIDTH-1:1]}.
  - bit_cnt <= bit_cnt+1.
  - out_carry <= cout_in.
- COLLECT, accept with bit_cnt==WIDTH-1: state -> FULL and bit_cnt -> WIDTH. out_valid rises the cycle after the last accept, giving a latency of 1 cycle from the final bit.
- COLLECT, in_valid low: hold all state. Gaps of any length are legal.
- FULL:
  - in_ready = 0; in_valid is ignored.
  - out_word and out_carry are stable while out_ready is low, for any number of cycles.
- FULL with out_ready high: state -> COLLECT, bit_cnt -> 0, shift register -> 0. The next bit can be accepted the following cycle, so minimum throughput is one word per WIDTH+1 cycles.
- No same-cycle drain-and-fill: a bit is never accepted in a cycle where out_valid is 1.
- flush:
  - Highest synchronous priority; it overrides accept and drain in the same cycle.
  - Next state is COLLECT with bit_cnt = 0, shift register = 0, out_carry = 0, out_valid = 0, ovf_sticky = 0.
  - Dropping a FULL word via flush is legal.
- out_word equals the shift register. Its value is only defined for downstream when out_valid = 1, but it must still equal the register contents at all times.
- bit_cnt never exceeds WIDTH and never wraps.

Optional Feature:
- Macro: SERIAL_SUM_OVF_STICKY_EN.
- Defined:
  - ovf_sticky sets on the cycle a word with out_carry=1 is drained (out_valid && out_ready && out_carry).
  - Remains set until rst_n or flush.
  - Draining further words never clears it.
- Undefined: ovf_sticky is tied to 0 and no flag register is built. The port list is identical in both builds.

Test Plan:
- Default build, WIDTH=4, out_ready=1: accept sum_in 1,0,1,1 with cout_in 0,0,0,1 on consecutive cycles -> out_valid high the next cycle, out_word=4'b1101, out_carry=1, bit_cnt=4; out_valid low 1 cycle later; in_ready low exactly 1 cycle.
- Backpressure: complete the word 4'b0110 with out_ready=0 for 5 cycles while in_valid=1 -> out_word held at 4'b0110, in_ready=0, no bits consumed; out_ready=1 -> drain, then the next frame starts with bit_cnt=0.
- Gaps: in_valid pattern 1,0,0,1,0,1,1 with sum bits 0,1,1,0 on the valid cycles -> out_word=4'b0110; bit_cnt increments only on valid cycles.
- Flush mid-frame after 2 bits, then flush in FULL with out_ready=1 in the same cycle -> both cases return bit_cnt=0, out_valid=0; the word is not counted as drained.
- rst_n pulsed low mid-clock at bit 3 -> outputs clear immediately without a clock edge; after release, a fresh 4-bit frame assembles correctly.
- With SERIAL_SUM_OVF_STICKY_EN: drain one word with out_carry=1 and then one with out_carry=0 -> ovf_sticky=1 and stays 1; flush -> 0. Without the macro, ovf_sticky=0 throughout.
